uart_rx_fifo: RTL and testbench

//  UART receive front-end on the user-project UART path (pad mprj_io[15] -> core).

---
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with programmable divisor feeding a FWFT byte FIFO
module uart_rx_fifo #(
  parameter int DIV_W      = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_uart_rx,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic [LVL_W-1:0] o_fifo_level,
  output logic             o_frame_err,
  output logic             o_overrun
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic             sync1_q, rx_s_q;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             ferr_q, ferr_d;

  logic             cnt_zero;
  logic [DIV_W-1:0] div_eff;

  assign cnt_zero = (cnt_q == '0);
  assign div_eff  = (i_baud_div < MIN_DIV) ? MIN_DIV : i_baud_div;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= MIN_DIV;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
    end
  end

  // The divisor is captured at start detect so a mid-frame change cannot corrupt timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          div_d   = div_eff;
          cnt_d   = (div_eff >> 1) - DIV_W'(1);
        end
      end
      S_START: begin
        if (cnt_zero) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = div_q - DIV_W'(1);
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = div_q - DIV_W'(1);
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - DIV_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_d = 1'b0;
    ferr_d = 1'b0;
    if (state_q == S_STOP && cnt_zero) begin
      push_d = rx_s_q;
      ferr_d = !rx_s_q;
    end
  end

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             ovr_q;
  logic             full, empty, pop, wr_en;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign pop   = !empty && i_rx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
      ovr_q   <= push_q && full && !pop;
    end
  end

  assign o_rx_data    = mem_q[rd_ptr_q];
  assign o_rx_valid   = !empty;
  assign o_fifo_level = level_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scenario tasks driving serial frames against a queue-based receive model
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] div;
  logic        rx;
  logic        ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  level;
  logic        frame_err;
  logic        overrun;

  uart_rx_fifo dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_baud_div(div), .i_uart_rx(rx),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(ready),
    .o_fifo_level(level), .o_frame_err(frame_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] got[$];
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid && ready) got.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic send_bits(input logic [9:0] fr, input int n, input int cpb);
    for (int b = 0; b < n; b++) begin
      rx = fr[b];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int cpb);
    send_bits({stop_bit, d, 1'b0}, 10, cpb);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
  endtask

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] v;
    v = 8'hxx;
    if (i < got.size()) v = got[i];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0; div = 24'd434;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_single();
    int lat;
    int exp_lat;
    div = 24'd434; ready = 1'b0;
    clear_mon();
    lat = -1;
    // sync (2) + detect (1) + half bit + nine bit times + push (1)
    exp_lat = 9 * 434 + 434 / 2 + 4;
    fork
      send_byte(8'hA5, 1'b1, 434);
      begin
        for (int c = 1; c <= 6000; c++) begin
          @(posedge clk);
          #1;
          if (rx_valid) begin lat = c; break; end
        end
      end
    join
    idle(10);
    total++; if (lat < exp_lat - 4 || lat > exp_lat + 4) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, exp_lat); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", rx_data); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt); end
    ready = 1'b1;
    idle(5);
    ready = 1'b0;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL single_drain got=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3];
    exp = '{8'h00, 8'hFF, 8'h3C};
    div = 24'd4; ready = 1'b1;
    clear_mon();
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1, 4);
    idle(20);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got_at(i) !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_at(i), exp[i]); end
    end
    total++; if (ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL b2b_errors got=%0d exp=0", ferr_cnt + ovr_cnt); end
  endtask

  task automatic test_overrun();
    div = 24'd8; ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 8);
    idle(30);
    total++; if (level !== 4'd8) begin bad++; $display("FAIL ovr_level got=%0d exp=8", level); end
    total++; if (ovr_cnt !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL ovr_ferr got=%0d exp=0", ferr_cnt); end
    total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL ovr_head got=%h exp=01", rx_data); end
    ready = 1'b1;
    idle(20);
    ready = 1'b0;
    total++; if (got.size() !== 8) begin bad++; $display("FAIL ovr_drain_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      total++; if (got_at(i) !== 8'(i + 1)) begin bad++; $display("FAIL ovr_drain%0d got=%h exp=%h", i, got_at(i), 8'(i + 1)); end
    end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL ovr_empty got=%0d exp=0", level); end
  endtask

  task automatic test_frame_err();
    div = 24'd8; ready = 1'b1;
    clear_mon();
    send_byte(8'h55, 1'b0, 8);
    idle(30);
    total++; if (ferr_cnt !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt); end
    total++; if (got.size() !== 0 || level !== 4'd0) begin bad++; $display("FAIL ferr_nopush got=%0d exp=0", got.size()); end
    send_byte(8'h66, 1'b1, 8);
    idle(30);
    total++; if (got.size() !== 1 || got_at(0) !== 8'h66) begin bad++; $display("FAIL ferr_next got=%h exp=66", got_at(0)); end
    total++; if (ferr_cnt !== 1) begin bad++; $display("FAIL ferr_after got=%0d exp=1", ferr_cnt); end
  endtask

  task automatic test_glitch();
    div = 24'd16; ready = 1'b1;
    clear_mon();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(60);
    total++; if (got.size() !== 0 || level !== 4'd0) begin bad++; $display("FAIL glitch_push got=%0d exp=0", got.size()); end
    total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_reset_mid();
    div = 24'd8; ready = 1'b0;
    clear_mon();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 8);
    idle(20);
    total++; if (level !== 4'd3) begin bad++; $display("FAIL rmid_level got=%0d exp=3", level); end
    send_bits({1'b1, 8'hC3, 1'b0}, 4, 8);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (rx_valid !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL rmid_async got=%b/%0d exp=0/0", rx_valid, level); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", rx_data); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    ready = 1'b1;
    clear_mon();
    send_byte(8'h7E, 1'b1, 8);
    idle(30);
    total++; if (got.size() !== 1 || got_at(0) !== 8'h7E) begin bad++; $display("FAIL rmid_next got=%h n=%0d exp=7e", got_at(0), got.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int dv;
    int cpb;
    ready = 1'b1;
    clear_mon();
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      dv = $urandom_range(0, 12);
      cpb = (dv < 4) ? 4 : dv;
      div = 24'(dv);
      send_byte(d, 1'b1, cpb);
      exp_q.push_back(d);
      idle($urandom_range(0, 2) * cpb);
    end
    idle(40);
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got_at(i) !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_at(i), exp_q[i]); end
    end
    total++; if (ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL rand_errors got=%0d exp=0", ferr_cnt + ovr_cnt); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL err_exclusive got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    ready = 1'b0;
    div = 24'd434;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
